// File: rtl/stack_pkg.sv
// Shared command encoding and modulo-DEPTH pointer helpers for the stack block.
package stack_pkg;

  typedef enum logic [1:0] {
    CMD_NOP  = 2'b00,
    CMD_PUSH = 2'b01,
    CMD_POP  = 2'b10,
    CMD_GET  = 2'b11
  } cmd_e;

  // Advance a ring pointer, wrapping at depth with an explicit compare so
  // non-power-of-two depths work.
  function automatic int unsigned ptr_inc(input int unsigned ptr, input int unsigned depth);
    return (ptr == depth - 1) ? 0 : ptr + 1;
  endfunction

  // Step a ring pointer back, wrapping from 0 to depth-1.
  function automatic int unsigned ptr_dec(input int unsigned ptr, input int unsigned depth);
    return (ptr == 0) ? depth - 1 : ptr - 1;
  endfunction

endpackage

// File: rtl/stack_ram.sv
// DEPTH x WIDTH register array: one synchronous write port, one combinational
// read port. The array is deliberately not reset.
module stack_ram #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned DEPTH = 5,
  parameter int unsigned AW    = 3
) (
  input  logic             i_clk,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic [AW-1:0]    i_raddr,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  // Write the addressed entry on the rising edge when enabled.
  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/stack_behaviour_param.sv
// Parametrised LIFO with registered read data, occupancy flags, sticky error
// and optional ring-overwrite on push when full.
module stack_behaviour_param
  import stack_pkg::*;
#(
  parameter  int unsigned WIDTH = 4,
  parameter  int unsigned DEPTH = 5,
  parameter  int unsigned WRAP  = 0,
  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [1:0]       COMMAND,
  input  logic [IDX_W-1:0] INDEX,
  input  logic [WIDTH-1:0] I_DATA,
  output logic [WIDTH-1:0] O_DATA,
  output logic             O_VALID,
  output logic [CW-1:0]    COUNT,
  output logic             FULL,
  output logic             EMPTY,
  output logic             ERROR
);

  logic [IDX_W-1:0] r_top;
  logic [CW-1:0]    r_count;
  logic             r_full;
  logic             r_empty;
  logic             r_error;
  logic             r_valid;
  logic [WIDTH-1:0] r_data;

  cmd_e             w_cmd;
  logic             w_get_ok;
  logic [IDX_W-1:0] w_off;
  logic [IDX_W:0]   w_sum;
  logic [IDX_W-1:0] w_rd_addr;
  logic [WIDTH-1:0] w_rdata;
  logic             w_we;
  logic [IDX_W-1:0] w_top_nxt;
  logic [CW-1:0]    w_cnt_nxt;
  logic             w_err_nxt;
  logic             w_valid_nxt;
  logic [WIDTH-1:0] w_data_nxt;

  assign w_cmd    = cmd_e'(COMMAND);
  assign w_get_ok = (CW'(INDEX) < r_count);

  // Read address = (TOP-1-k) mod DEPTH; k is 0 for POP, INDEX for a legal GET.
  // Adding DEPTH-1 first keeps the sum non-negative, so one compare-subtract wraps it.
  always_comb begin
    w_off = '0;
    if (w_cmd == CMD_GET && w_get_ok) w_off = INDEX;
    w_sum = {1'b0, r_top} + (IDX_W+1)'(DEPTH - 1) - {1'b0, w_off};
    if (w_sum >= (IDX_W+1)'(DEPTH)) w_rd_addr = IDX_W'(w_sum - (IDX_W+1)'(DEPTH));
    else                            w_rd_addr = IDX_W'(w_sum);
  end

  stack_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (IDX_W)
  ) u_ram (
    .i_clk   (CLK),
    .i_we    (w_we && !RESET),
    .i_waddr (r_top),
    .i_wdata (I_DATA),
    .i_raddr (w_rd_addr),
    .o_rdata (w_rdata)
  );

  // Decode the command into next pointer, count, error and output values.
  always_comb begin
    w_we        = 1'b0;
    w_top_nxt   = r_top;
    w_cnt_nxt   = r_count;
    w_err_nxt   = r_error;
    w_valid_nxt = 1'b0;
    w_data_nxt  = r_data;
    case (w_cmd)
      CMD_PUSH: begin
        if (!r_full) begin
          w_we      = 1'b1;
          w_top_nxt = IDX_W'(ptr_inc(32'(r_top), DEPTH));
          w_cnt_nxt = r_count + CW'(1);
        end else if (WRAP != 0) begin
          w_we      = 1'b1;
          w_top_nxt = IDX_W'(ptr_inc(32'(r_top), DEPTH));
        end else begin
          w_err_nxt = 1'b1;
        end
      end
      CMD_POP: begin
        if (!r_empty) begin
          w_data_nxt  = w_rdata;
          w_valid_nxt = 1'b1;
          w_top_nxt   = IDX_W'(ptr_dec(32'(r_top), DEPTH));
          w_cnt_nxt   = r_count - CW'(1);
        end else begin
          w_err_nxt = 1'b1;
        end
      end
      CMD_GET: begin
        if (w_get_ok) begin
          w_data_nxt  = w_rdata;
          w_valid_nxt = 1'b1;
        end else begin
          w_err_nxt = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Register control state and outputs; reset overrides any command.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_top   <= '0;
      r_count <= '0;
      r_full  <= 1'b0;
      r_empty <= 1'b1;
      r_error <= 1'b0;
      r_valid <= 1'b0;
      r_data  <= '0;
    end else begin
      r_top   <= w_top_nxt;
      r_count <= w_cnt_nxt;
      r_full  <= (w_cnt_nxt == CW'(DEPTH));
      r_empty <= (w_cnt_nxt == '0);
      r_error <= w_err_nxt;
      r_valid <= w_valid_nxt;
      r_data  <= w_data_nxt;
    end
  end

  assign O_DATA  = r_data;
  assign O_VALID = r_valid;
  assign COUNT   = r_count;
  assign FULL    = r_full;
  assign EMPTY   = r_empty;
  assign ERROR   = r_error;

endmodule

// File: tb/tb_stack_behaviour_param.sv
// Bench for stack_behaviour_param: three configurations (strict 4x5, ring 4x5,
// strict 8x3) share one command stream; a queue-based LIFO model predicts each.
module tb_stack_behaviour_param;

  localparam int P_W    [3] = '{4, 4, 8};
  localparam int P_D    [3] = '{5, 5, 3};
  localparam int P_WRAP [3] = '{0, 1, 0};
  localparam int P_IW   [3] = '{3, 3, 2};

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] cmd;
  logic [7:0] din;
  logic [2:0] idx5;
  logic [1:0] idx3;

  logic [3:0] od0, od1;
  logic [7:0] od2;
  logic       ov0, ov1, ov2;
  logic [2:0] c0, c1;
  logic [1:0] c2;
  logic       f0, f1, f2, e0, e1, e2, er0, er1, er2;

  always #5 clk = ~clk;

  stack_behaviour_param #(.WIDTH(4), .DEPTH(5), .WRAP(0)) u_strict (
    .CLK(clk), .RESET(rst), .COMMAND(cmd), .INDEX(idx5), .I_DATA(din[3:0]),
    .O_DATA(od0), .O_VALID(ov0), .COUNT(c0), .FULL(f0), .EMPTY(e0), .ERROR(er0));

  stack_behaviour_param #(.WIDTH(4), .DEPTH(5), .WRAP(1)) u_ring (
    .CLK(clk), .RESET(rst), .COMMAND(cmd), .INDEX(idx5), .I_DATA(din[3:0]),
    .O_DATA(od1), .O_VALID(ov1), .COUNT(c1), .FULL(f1), .EMPTY(e1), .ERROR(er1));

  stack_behaviour_param #(.WIDTH(8), .DEPTH(3), .WRAP(0)) u_small (
    .CLK(clk), .RESET(rst), .COMMAND(cmd), .INDEX(idx3), .I_DATA(din),
    .O_DATA(od2), .O_VALID(ov2), .COUNT(c2), .FULL(f2), .EMPTY(e2), .ERROR(er2));

  typedef struct {
    bit v;
    int d;
    int cnt;
    bit full;
    bit empty;
    bit err;
  } exp_t;

  exp_t exp_q[$];
  int   stk [3][$];
  int   m_data [3];
  bit   m_err [3];

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  task automatic chk(input string name, input int inst, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s inst=%0d cyc=%0d: got %0d expected %0d", name, inst, cyc, act, exp);
    end
  endtask

  // Reference model: the stack is a queue whose back is the top entry.
  task automatic model_step(input int k, input bit r, input int c, input int d, input int ix);
    int   mask, i, sz;
    exp_t e;
    mask = (1 << P_W[k]) - 1;
    e.v  = 1'b0;
    if (r) begin
      stk[k].delete();
      m_err[k]  = 1'b0;
      m_data[k] = 0;
    end else begin
      sz = stk[k].size();
      case (c)
        1: begin
          if (sz < P_D[k]) stk[k].push_back(d & mask);
          else if (P_WRAP[k] != 0) begin
            void'(stk[k].pop_front());
            stk[k].push_back(d & mask);
          end else m_err[k] = 1'b1;
        end
        2: begin
          if (sz > 0) begin
            m_data[k] = stk[k].pop_back();
            e.v = 1'b1;
          end else m_err[k] = 1'b1;
        end
        3: begin
          i = ix & ((1 << P_IW[k]) - 1);
          if (i < sz) begin
            m_data[k] = stk[k][sz - 1 - i];
            e.v = 1'b1;
          end else m_err[k] = 1'b1;
        end
        default: ;
      endcase
    end
    e.d     = m_data[k];
    e.cnt   = stk[k].size();
    e.full  = (stk[k].size() == P_D[k]);
    e.empty = (stk[k].size() == 0);
    e.err   = m_err[k];
    exp_q.push_back(e);
  endtask

  task automatic drive(input bit r, input int c, input int d, input int ix);
    rst  = r;
    cmd  = c[1:0];
    din  = d[7:0];
    idx5 = ix[2:0];
    idx3 = ix[1:0];
    for (int k = 0; k < 3; k++) model_step(k, r, c, d, ix);
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int d);  drive(1'b0, 1, d, 0);  endtask
  task automatic pop();              drive(1'b0, 2, 0, 0);  endtask
  task automatic get(input int ix);  drive(1'b0, 3, 0, ix); endtask
  task automatic reset_cycle();      drive(1'b1, 0, 0, 0);  endtask

  // Monitor: every falling edge pops the prediction for the edge just taken.
  initial begin
    exp_t e;
    int   a_v, a_d, a_c, a_f, a_e, a_er;
    forever begin
      @(negedge clk);
      cyc++;
      if (exp_q.size() >= 3) begin
        for (int k = 0; k < 3; k++) begin
          e = exp_q.pop_front();
          case (k)
            0: begin a_v = int'(ov0); a_d = int'(od0); a_c = int'(c0); a_f = int'(f0); a_e = int'(e0); a_er = int'(er0); end
            1: begin a_v = int'(ov1); a_d = int'(od1); a_c = int'(c1); a_f = int'(f1); a_e = int'(e1); a_er = int'(er1); end
            default: begin a_v = int'(ov2); a_d = int'(od2); a_c = int'(c2); a_f = int'(f2); a_e = int'(e2); a_er = int'(er2); end
          endcase
          chk("O_VALID", k, a_v, int'(e.v));
          chk("O_DATA", k, a_d, e.d);
          chk("COUNT", k, a_c, e.cnt);
          chk("FULL", k, a_f, int'(e.full));
          chk("EMPTY", k, a_e, int'(e.empty));
          chk("ERROR", k, a_er, int'(e.err));
        end
      end
    end
  end

  initial begin
    int r, c;
    // Reset and fill, then read every depth.
    reset_cycle();
    reset_cycle();
    for (int i = 1; i <= 5; i++) push(i);
    for (int i = 0; i < 5; i++) get(i);
    // Overflow on full, drain, then underflow.
    push(6);
    for (int i = 0; i < 5; i++) pop();
    pop();
    // Ring overwrite.
    reset_cycle();
    for (int i = 1; i <= 7; i++) push(i);
    for (int i = 0; i < 5; i++) pop();
    // Underflow and bad index.
    reset_cycle();
    pop();
    reset_cycle();
    push(9);
    get(3);
    get(7);
    // Reset in the same cycle as a POP.
    reset_cycle();
    push(1); push(2); push(3);
    drive(1'b1, 2, 0, 0);
    push(4);
    get(0);
    // Wide data on the small stack, then a second fill with the pointer moving.
    reset_cycle();
    push(8'hA5); push(8'h5A); push(8'hFF);
    get(2);
    for (int i = 0; i < 3; i++) pop();
    pop();
    push(8'h11); push(8'h22); pop(); push(8'h33); push(8'h44); push(8'h55);
    get(0); get(1); get(2);
    for (int i = 0; i < 4; i++) pop();
    // Randomized traffic with occasional resets.
    for (int n = 0; n < 400; n++) begin
      r = $urandom_range(0, 99);
      if (r < 3)       c = -1;
      else if (r < 13) c = 0;
      else if (r < 50) c = 1;
      else if (r < 75) c = 2;
      else             c = 3;
      if (c < 0) reset_cycle();
      else drive(1'b0, c, int'($urandom_range(0, 255)), int'($urandom_range(0, 7)));
    end
    drive(1'b0, 0, 0, 0);
    @(negedge clk);
    #1;
    chk("scoreboard_drained", 0, exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  // Hard time limit so the run always terminates.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
